// File: rtl/grid_readout_pkg.sv
// Shared sudoku grid dimensions and readout state encoding.
// Used by both the grid generator and the readout block.
package grid_readout_pkg;
  localparam int GRID_ORD     = 3;
  localparam int GRID_LEN     = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA    = GRID_LEN * GRID_LEN;
  localparam int GRID_DIGIT_W = $clog2(GRID_LEN);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } readout_state_t;

  // Width of a binary digit / row / column index for a grid of the given order.
  function automatic int digit_width(input int ord);
    return $clog2(ord * ord);
  endfunction
endpackage

// File: rtl/grid_readout_if.sv
// Grid-to-readout inputs plus the valid/ready tile stream.
// master: the readout block; slave: the grid/sink side.
interface grid_readout_if
  import grid_readout_pkg::*;
#(
  parameter int ORD = GRID_ORD
);
  localparam int LEN  = ORD * ORD;
  localparam int AREA = LEN * LEN;
  localparam int DW   = digit_width(ORD);

  logic                 req;
  logic                 grid_done;
  logic                 grid_success;
  logic [AREA*LEN-1:0]  grid_values;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_digit;
  logic [DW-1:0]        out_row;
  logic [DW-1:0]        out_col;
  logic                 out_last;
  logic                 out_bad;
  logic                 busy;
  logic                 nack;

  modport master (
    input  req, grid_done, grid_success, grid_values, out_ready,
    output out_valid, out_digit, out_row, out_col, out_last, out_bad, busy, nack
  );

  modport slave (
    output req, grid_done, grid_success, grid_values, out_ready,
    input  out_valid, out_digit, out_row, out_col, out_last, out_bad, busy, nack
  );
endinterface

// File: rtl/onehot_to_bin.sv
// One-hot tile value to binary digit; lowest set bit wins, zero maps to 0.
// bad flags any value that is not exactly one-hot (zero or multi-hot).
module onehot_to_bin #(
  parameter  int LEN     = 9,
  localparam int DIGIT_W = $clog2(LEN)
) (
  input  logic [LEN-1:0]     value,
  output logic [DIGIT_W-1:0] digit,
  output logic               bad
);
  always_comb begin
    digit = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (value[i]) digit = DIGIT_W'(i);
    end
  end

  assign bad = ($countones(value) != 1);
endmodule

// File: rtl/grid_readout.sv
// Snapshots a solved grid on request and streams one tile per beat, row-major.
// First beat 1 cycle after req; holds fields while out_valid & !out_ready.
module grid_readout
  import grid_readout_pkg::*;
#(
  parameter int ORD = GRID_ORD
) (
  input  logic           clock,
  input  logic           reset,
  grid_readout_if.master bus
);
  localparam int LEN     = ORD * ORD;
  localparam int AREA    = LEN * LEN;
  localparam int DIGIT_W = digit_width(ORD);
  localparam int IDX_W   = $clog2(AREA);

  readout_state_t      state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [DIGIT_W-1:0]  row, row_next;
  logic [DIGIT_W-1:0]  col, col_next;
  logic                nack_q, nack_next;
  logic                load;
  logic [AREA*LEN-1:0] snapshot;
  logic [LEN-1:0]      tile;
  logic [DIGIT_W-1:0]  digit;
  logic                tile_bad;
  logic                last;
  logic                streaming;

  assign streaming = (state == STREAM);
  assign last      = (idx == IDX_W'(AREA - 1));

  always_comb begin
    state_next = state;
    idx_next   = idx;
    row_next   = row;
    col_next   = col;
    nack_next  = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (bus.grid_done && bus.grid_success) begin
            load       = 1'b1;
            state_next = STREAM;
            idx_next   = '0;
            row_next   = '0;
            col_next   = '0;
          end else begin
            nack_next = 1'b1;
          end
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (last) begin
            state_next = IDLE;
            idx_next   = '0;
            row_next   = '0;
            col_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
            // Row/column tracked as counters so no divide by LEN is needed.
            if (col == DIGIT_W'(LEN - 1)) begin
              col_next = '0;
              row_next = row + 1'b1;
            end else begin
              col_next = col + 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      row    <= '0;
      col    <= '0;
      nack_q <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      row    <= row_next;
      col    <= col_next;
      nack_q <= nack_next;
    end
  end

  // Snapshot carries no reset; it is only observed while streaming.
  always_ff @(posedge clock) begin
    if (load && !reset) snapshot <= bus.grid_values;
  end

  assign tile = snapshot[int'(idx)*LEN +: LEN];

  onehot_to_bin #(.LEN(LEN)) u_conv (
    .value (tile),
    .digit (digit),
    .bad   (tile_bad)
  );

  assign bus.out_valid = streaming;
  assign bus.busy      = streaming;
  assign bus.nack      = nack_q;
  assign bus.out_last  = streaming && last;
  assign bus.out_bad   = streaming && tile_bad;
  assign bus.out_digit = streaming ? digit : '0;
  assign bus.out_row   = streaming ? row : '0;
  assign bus.out_col   = streaming ? col : '0;
endmodule

// File: tb/tb_grid_readout.sv
// Directed vector table plus hand-written stream sequences for grid_readout (ORD=2 and ORD=3).
module tb_grid_readout;
  import grid_readout_pkg::*;

  localparam int L2 = 4;
  localparam int A2 = 16;
  localparam int L3 = 9;
  localparam int A3 = 81;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  grid_readout_if #(.ORD(2)) bus2 ();
  grid_readout_if #(.ORD(3)) bus3 ();

  grid_readout #(.ORD(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  grid_readout #(.ORD(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  typedef struct {
    logic rq, dn, sc, rdy;
    int   v, bz, nk, rw, cl, dg, lst;
  } vec_t;

  vec_t vt [13];
  int   sol  [16];
  int   sol2 [16];
  logic [A2*L2-1:0] mal;
  logic [A3*L3-1:0] gv3;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect2(input string tag, input int v, input int bz, input int nk,
                         input int rw, input int cl, input int dg, input int lst, input int bd);
    check({tag, ".valid"}, int'(bus2.out_valid), v);
    check({tag, ".busy"},  int'(bus2.busy), bz);
    check({tag, ".nack"},  int'(bus2.nack), nk);
    check({tag, ".row"},   int'(bus2.out_row), rw);
    check({tag, ".col"},   int'(bus2.out_col), cl);
    check({tag, ".digit"}, int'(bus2.out_digit), dg);
    check({tag, ".last"},  int'(bus2.out_last), lst);
    check({tag, ".bad"},   int'(bus2.out_bad), bd);
  endtask

  function automatic logic [A2*L2-1:0] pack2(input int d [16]);
    logic [A2*L2-1:0] v;
    v = '0;
    for (int t = 0; t < A2; t++) v[t*L2 + d[t]] = 1'b1;
    return v;
  endfunction

  function automatic int dig3(input int r, input int c);
    return (r * 3 + r / 3 + c) % 9;
  endfunction

  initial begin
    int n;
    logic hold, rdy;
    int s_row, s_col, s_dig, s_last, s_bad;

    sol = '{0, 1, 2, 3,  2, 3, 0, 1,  1, 0, 3, 2,  3, 2, 1, 0};
    for (int t = 0; t < A2; t++) sol2[t] = (sol[t] + 1) % 4;

    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, 0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 1, 1, 0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 2, 2, 0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 2, 2, 0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 3, 3, 0};

    bus2.req = 1'b0; bus2.grid_done = 1'b0; bus2.grid_success = 1'b0;
    bus2.out_ready = 1'b0; bus2.grid_values = pack2(sol);
    bus3.req = 1'b0; bus3.grid_done = 1'b0; bus3.grid_success = 1'b0;
    bus3.out_ready = 1'b0; bus3.grid_values = '0;

    // Reset state
    tick();
    tick();
    expect2("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset3.valid", int'(bus3.out_valid), 0);
    reset = 1'b0;

    // Table: refusals, acceptance, stall, ignored req mid-stream
    for (int i = 0; i < 13; i++) begin
      bus2.req = vt[i].rq; bus2.grid_done = vt[i].dn;
      bus2.grid_success = vt[i].sc; bus2.out_ready = vt[i].rdy;
      tick();
      expect2($sformatf("vec%0d", i), vt[i].v, vt[i].bz, vt[i].nk,
              vt[i].rw, vt[i].cl, vt[i].dg, vt[i].lst, 0);
    end
    reset = 1'b1; bus2.req = 1'b0;
    tick();
    expect2("vec_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Nominal stream, then back-to-back restart from a fresh snapshot
    bus2.grid_done = 1'b1; bus2.grid_success = 1'b1; bus2.out_ready = 1'b1;
    bus2.req = 1'b1;
    tick();
    bus2.req = 1'b0;
    for (int b = 0; b < A2; b++) begin
      expect2($sformatf("nom%0d", b), 1, 1, 0, b / 4, b % 4, sol[b], int'(b == 15), 0);
      tick();
    end
    check("nom_end.valid", int'(bus2.out_valid), 0);
    check("nom_end.busy", int'(bus2.busy), 0);
    bus2.grid_values = pack2(sol2);
    bus2.req = 1'b1;
    tick();
    bus2.req = 1'b0;
    for (int b = 0; b < A2; b++) begin
      expect2($sformatf("b2b%0d", b), 1, 1, 0, b / 4, b % 4, sol2[b], int'(b == 15), 0);
      tick();
    end
    check("b2b_end.valid", int'(bus2.out_valid), 0);

    // Malformed tiles: (1,2) zero, (3,3) multi-hot
    mal = pack2(sol);
    mal[6*L2 +: L2]  = 4'b0000;
    mal[15*L2 +: L2] = 4'b0110;
    bus2.grid_values = mal;
    bus2.req = 1'b1;
    tick();
    bus2.req = 1'b0;
    for (int b = 0; b < A2; b++) begin
      expect2($sformatf("mal%0d", b), 1, 1, 0, b / 4, b % 4,
              (b == 6) ? 0 : (b == 15) ? 1 : sol[b], int'(b == 15), int'(b == 6 || b == 15));
      tick();
    end

    // Reset after the 5th transfer, with req held high across the reset edge
    bus2.grid_values = pack2(sol);
    bus2.req = 1'b1;
    tick();
    bus2.req = 1'b0;
    for (int b = 0; b < 5; b++) tick();
    expect2("mid5", 1, 1, 0, 1, 1, sol[5], 0, 0);
    reset = 1'b1; bus2.req = 1'b1;
    tick();
    expect2("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect2("restart", 1, 1, 0, 0, 0, sol[0], 0, 0);
    bus2.req = 1'b0;
    for (int b = 0; b < A2; b++) tick();
    check("restart_end.valid", int'(bus2.out_valid), 0);

    // ORD=3 random backpressure with mid-stream grid corruption
    gv3 = '0;
    for (int t = 0; t < A3; t++) gv3[t*L3 + dig3(t / 9, t % 9)] = 1'b1;
    bus3.grid_values = gv3; bus3.grid_done = 1'b1; bus3.grid_success = 1'b1;
    bus3.req = 1'b1;
    tick();
    bus3.req = 1'b0;
    n = 0; hold = 1'b0;
    s_row = 0; s_col = 0; s_dig = 0; s_last = 0; s_bad = 0;
    for (int cyc = 0; cyc < 2000 && n < A3; cyc++) begin
      check("bp.valid", int'(bus3.out_valid), 1);
      if (hold) begin
        check("bp_hold.row",   int'(bus3.out_row), s_row);
        check("bp_hold.col",   int'(bus3.out_col), s_col);
        check("bp_hold.digit", int'(bus3.out_digit), s_dig);
        check("bp_hold.last",  int'(bus3.out_last), s_last);
        check("bp_hold.bad",   int'(bus3.out_bad), s_bad);
      end
      if (n == 40) bus3.grid_values = '1;
      rdy = 1'($urandom_range(0, 1));
      bus3.out_ready = rdy;
      if (rdy) begin
        check($sformatf("bp%0d.row", n),   int'(bus3.out_row), n / 9);
        check($sformatf("bp%0d.col", n),   int'(bus3.out_col), n % 9);
        check($sformatf("bp%0d.digit", n), int'(bus3.out_digit), dig3(n / 9, n % 9));
        check($sformatf("bp%0d.last", n),  int'(bus3.out_last), int'(n == A3 - 1));
        check($sformatf("bp%0d.bad", n),   int'(bus3.out_bad), 0);
        n++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        s_row = int'(bus3.out_row); s_col = int'(bus3.out_col);
        s_dig = int'(bus3.out_digit); s_last = int'(bus3.out_last); s_bad = int'(bus3.out_bad);
      end
      tick();
    end
    check("bp.count", n, A3);
    check("bp_end.valid", int'(bus3.out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grid_readout.md
Name: grid_readout

Overview:
- Downstream consumer of the sudoku grid generator; provides the grid's solution-readout interface.
- After the grid reports done+success, a request snapshots all tile values and streams them out one tile per beat, in row-major order, over a valid/ready handshake.
- Each tile's one-hot value is converted to a binary digit, tagged with row/col, and flagged if malformed.
- Sits between the grid and any serial sink (UART framer, testbench scoreboard).

Parameters:
- ORD, 3, grid order. LEN = ORD*ORD (values per row); AREA = LEN*LEN (tiles).
- DIGIT_W, $clog2(LEN), width of out_digit, out_row and out_col.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  readout request; sampled only in IDLE.
- grid_done  in  1  grid finished (success or failure).
- grid_success  in  1  grid finished with a valid solution.
- grid_values  in  AREA*LEN  row-major one-hot tile values; tile (r,c) occupies bits [(r*LEN+c)*LEN +: LEN].
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts beat.
- out_digit  out  DIGIT_W  binary index of the set bit (0..LEN-1).
- out_row  out  DIGIT_W  row of current beat.
- out_col  out  DIGIT_W  column of current beat.
- out_last  out  1  current beat is tile AREA-1.
- out_bad  out  1  current tile value is not exactly one-hot.
- busy  out  1  high in STREAM.
- nack  out  1  one-cycle pulse: request refused.

Behaviour:
- Clock/reset: clock is the clock. reset is synchronous and active-high. Reset dominates all other inputs on the same edge.
- Reset values: state=IDLE, idx=0, out_valid=0, busy=0, nack=0, out_last=0, out_bad=0, out_row=0, out_col=0, out_digit=0. The snapshot register is not reset.
- States: IDLE, STREAM.
- IDLE, req=1 with grid_done=1 and grid_success=1:
  - At that edge, snapshot <= grid_values, idx <= 0, state <= STREAM.
  - out_valid is high on the following cycle (1-cycle latency, req to first beat).
- IDLE, req=1 with grid_done=0 or grid_success=0:
  - nack=1 for exactly the next cycle; stay in IDLE.
  - req held high produces nack every cycle while the refusal condition holds.
- STREAM:
  - out_valid=1 and busy=1 continuously.
  - Beat fields derive from snapshot tile idx: out_row=idx/LEN, out_col=idx%LEN, out_last=(idx==AREA-1).
  - Implementation keeps separate row/col counters; no divider.
- Handshake: a beat transfers on a cycle where out_valid & out_ready.
  - On transfer with idx<AREA-1: idx increments and the column advances. The column wraps from LEN-1 to 0 and the row then increments.
  - On transfer with out_last=1: state <= IDLE, out_valid=0 next cycle.
  - While out_valid & !out_ready, all out_* fields hold stable.
  - Zero-bubble: a sink holding out_ready=1 receives AREA beats in AREA consecutive cycles.
- Input isolation in STREAM: req, grid_done, grid_success and grid_values are ignored. Changes to grid_values mid-stream do not affect output (snapshot).
- Digit conversion:
  - out_digit = index of the lowest set bit, or 0 if the value is zero.
  - out_bad = popcount != 1, covering both zero and multi-hot values.
  - out_bad is a flag only; streaming continues.
- Outputs are combinational from snapshot, idx and state. There are no combinational paths from out_ready to out_valid or to the data fields.
- Reset mid-stream: return to IDLE; out_valid=0 on the cycle after the reset edge; the partial stream is abandoned with no out_last.
- A new req in IDLE after completion re-snapshots the current grid_values.

Decomposition:
- Shared package/header (extends the grid dimensions header): GRID_ORD, GRID_LEN, GRID_AREA, derived DIGIT_W, and the readout state enum typedef. The grid and this block both use it.
- One sub-module: onehot_to_bin.
  - Parameter LEN; input LEN-bit one-hot; outputs DIGIT_W digit and bad flag.
  - Purely combinational; reusable by the grid print/debug paths.
- The tile mux (snapshot slice by idx) stays in grid_readout.

Test Plan:
- Nominal stream: ORD=2. grid_values holds a known valid 4x4 solution, grid_done=grid_success=1, pulse req, out_ready=1. Response:
  - 16 consecutive beats, first beat on the cycle after req.
  - (row,col) runs (0,0),(0,1)…(3,3); digits match the solution.
  - out_last only on beat 16; busy drops with out_valid; out_bad=0 throughout.
- Refusal: req with grid_done=1, grid_success=0 → nack=1 for one cycle, out_valid stays 0, state stays IDLE. Repeat with grid_done=0 → same.
- Backpressure: ORD=3, out_ready toggled pseudo-randomly. Response:
  - exactly 81 transfers in order, no duplicates or drops;
  - fields stable whenever valid & !ready;
  - grid_values changed mid-stream has no effect on the output.
- Malformed values: tile (1,2)=0 and tile (3,3)=4'b0110 (ORD=2) → beat 6 has out_bad=1, out_digit=0; beat 15 has out_bad=1, out_digit=1; all other beats have out_bad=0.
- Reset mid-stream: assert reset after the 5th transfer → out_valid=0 next cycle, outputs at reset values. A subsequent req restarts at (0,0).
- Back-to-back: after out_last transfers, assert req on the very next IDLE cycle → a new stream starts one cycle later, rebuilt from the fresh snapshot.
